mem_access_unit: RTL



---
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the word-wide data memory port
// Optional MISALIGN_TRAP_EN: reject misaligned and reserved-size accesses with resp_err.
module mem_access_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [2:0] RD_LAST = 3'(MEM_RD_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cap_q, cap_d;

  logic        req_err;
  logic [31:0] wr_word;
  logic [31:0] load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end
`else
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      cap_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      cap_q    <= cap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    cap_d    = cap_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          wdata_d  = req_wdata;
          err_d    = req_err;
          cnt_d    = '0;
          // size 11 shares the word path when trapping is disabled
          if (req_err)                      state_d = RESP;
          else if (req_write && req_size[1]) state_d = WR;
          else                               state_d = RD;
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          cap_d   = read_data;
          cnt_d   = '0;
          state_d = write_q ? WR : RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_word = cap_q;
    if (size_q[1]) begin
      wr_word = wdata_q;
    end else if (size_q[0]) begin
      if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
      else           wr_word[15:0]  = wdata_q[15:0];
    end else begin
      wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  assign byte_sel = cap_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? cap_q[31:16] : cap_q[15:0];

  always_comb begin
    load_val = cap_q;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_val = cap_q;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign MemRead     = (state_q == RD);
  assign MemWrite    = (state_q == WR);
  assign resp_valid  = (state_q == RESP);
  assign resp_err    = (state_q == RESP) && err_q;
  assign resp_rdata  = ((state_q == RESP) && !write_q && !err_q) ? load_val : 32'h0;
  assign mem_address = {2'b00, addr_q[31:2]};
  assign write_data  = write_q ? wr_word : 32'h0;

endmodule
